filter_storage: RTL and testbench

- Single-clock 512 x 16-bit storage array holding filter coefficients/samples for the filter datapath.
- One independent write port and one independent read port, usable in the same cycle.
- Registered read output, one-cycle latency.
- Whole array and output register are cleared by synchronous reset.

---
 rtl/filter_storage_if.sv | 23 ++
 rtl/filter_storage.sv | 34 +++
 tb/tb_filter_storage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/filter_storage_if.sv
// Write/read port bundle for filter_storage. The master drives the enables, pointers and write
// data. The slave (the storage) returns the registered read data.
interface filter_storage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic              wren;
  logic [ADDR_W-1:0] wrptr;
  logic [DATA_W-1:0] wrdata;
  logic              rden;
  logic [ADDR_W-1:0] rdptr;
  logic [DATA_W-1:0] rddata;

  modport master (
    output wren, wrptr, wrdata, rden, rdptr,
    input  rddata
  );

  modport slave (
    input  wren, wrptr, wrdata, rden, rdptr,
    output rddata
  );
endinterface

// File: rtl/filter_storage.sv
// 512x16 flop-based coefficient/sample store with independent write and read ports.
// The read data is registered, so it appears one cycle after rden is sampled.
// There is no backpressure: every enabled access completes in the cycle it is issued.
module filter_storage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  filter_storage_if.slave  bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The read samples the pre-edge array contents. A read and a write to the same address in
  // one cycle therefore return the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      bus.rddata <= '0;
    end else begin
      if (bus.wren) begin
        mem[bus.wrptr] <= bus.wrdata;
      end
      if (bus.rden) begin
        bus.rddata <= mem[bus.rdptr];
      end
    end
  end

endmodule

// File: tb/tb_filter_storage.sv
// Directed-vector bench for filter_storage. The driver queues a hand-computed rddata for each
// checked cycle, and a negedge monitor pops each value and compares it with the DUT.
module tb_filter_storage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  filter_storage_if #(.DATA_W(16), .ADDR_W(9)) bus ();

  filter_storage #(.DATA_W(16), .ADDR_W(9), .DEPTH(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [15:0] exp_q [$];
  string       name_q [$];
  int          vectors     = 0;
  int          miscompares = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      if (bus.rddata !== e) begin
        miscompares++;
        $display("FAIL %s: rddata=%h expected=%h", n, bus.rddata, e);
      end
    end
  end

  // One clock cycle of stimulus. When chk is set, exp is the rddata required after this edge.
  task automatic cyc(input bit rst, input bit we, input logic [8:0] wp, input logic [15:0] wd,
                     input bit re, input logic [8:0] rp, input bit chk, input logic [15:0] exp,
                     input string nm);
    rst_n      = ~rst;
    bus.wren   = we;
    bus.wrptr  = wp;
    bus.wrdata = wd;
    bus.rden   = re;
    bus.rdptr  = rp;
    @(posedge clk);
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [15:0] hold,
                    input string nm);
    cyc(1'b0, 1'b1, a, d, 1'b0, 9'd0, 1'b1, hold, nm);
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] exp, input string nm);
    cyc(1'b0, 1'b0, 9'd0, 16'h0, 1'b1, a, 1'b1, exp, nm);
  endtask

  initial begin
    logic [8:0]  wrap_ptr;
    logic [31:0] wide;
    wrap_ptr = 9'(0 + 513);
    wide     = 32'hAAAAAAAA;

    // Reset with both enables high: the write must be ignored and rddata cleared.
    cyc(1'b1, 1'b1, 9'd0, 16'hFFFF, 1'b1, 9'd0, 1'b1, 16'h0000, "reset_edge0");
    cyc(1'b1, 1'b1, 9'd0, 16'hFFFF, 1'b1, 9'd0, 1'b1, 16'h0000, "reset_edge1");
    rd(9'd0,   16'h0000, "post_reset_rd0");
    rd(9'd255, 16'h0000, "post_reset_rd255");
    rd(9'd511, 16'h0000, "post_reset_rd511");

    // Basic write/read, wrapped pointer (0+513 -> 1), and truncation of a wide driver value.
    wr(9'd0, 16'hAAAA, 16'h0000, "hold_during_wr0");
    wr(wrap_ptr, 16'hBBBB, 16'h0000, "hold_during_wr1");
    rd(9'd1, 16'hBBBB, "rd1_wrapped");
    rd(9'd0, 16'hAAAA, "rd0");
    wr(9'd2, wide[15:0], 16'hAAAA, "hold_during_wr2");
    rd(9'd2, 16'hAAAA, "rd2_truncated");

    // Boundary addresses.
    wr(9'd511, 16'h1234, 16'hAAAA, "hold_wr511");
    wr(9'd0,   16'h5678, 16'hAAAA, "hold_wr0b");
    rd(9'd511, 16'h1234, "rd511");
    rd(9'd0,   16'h5678, "rd0_boundary");

    // Same-address read-during-write returns the old word.
    wr(9'd5, 16'h1111, 16'h5678, "hold_wr5");
    cyc(1'b0, 1'b1, 9'd5, 16'h2222, 1'b1, 9'd5, 1'b1, 16'h1111, "rdw_same_addr_old");
    rd(9'd5, 16'h2222, "rd5_new");

    // Read/write to different addresses in the same cycle.
    cyc(1'b0, 1'b1, 9'd7, 16'h7070, 1'b1, 9'd1, 1'b1, 16'hBBBB, "rdw_diff_addr");
    rd(9'd7, 16'h7070, "rd7");

    // rddata holds while rden is low.
    wr(9'd0, 16'hAAAA, 16'h7070, "hold_wr0c");
    rd(9'd0, 16'hAAAA, "rd0_again");
    wr(9'd10, 16'h3333, 16'hAAAA, "hold_idle_a");
    wr(9'd11, 16'h4444, 16'hAAAA, "hold_idle_b");
    cyc(1'b0, 1'b0, 9'd0, 16'h0, 1'b0, 9'd10, 1'b1, 16'hAAAA, "hold_idle_c");
    rd(9'd10, 16'h3333, "rd10");
    rd(9'd11, 16'h4444, "rd11");

    // Back-to-back writes to the same address: the last write wins.
    wr(9'd12, 16'h4444, 16'h4444, "hold_wr12a");
    wr(9'd12, 16'h5555, 16'h4444, "hold_wr12b");
    rd(9'd12, 16'h5555, "rd12_last_wins");

    // Mid-operation reset with enables high clears everything and blocks the write.
    cyc(1'b1, 1'b1, 9'd20, 16'h7777, 1'b1, 9'd12, 1'b1, 16'h0000, "mid_reset");
    rd(9'd20,  16'h0000, "post_rst_rd20");
    rd(9'd0,   16'h0000, "post_rst_rd0");
    rd(9'd1,   16'h0000, "post_rst_rd1");
    rd(9'd5,   16'h0000, "post_rst_rd5");
    rd(9'd12,  16'h0000, "post_rst_rd12");
    rd(9'd511, 16'h0000, "post_rst_rd511");

    cyc(1'b0, 1'b0, 9'd0, 16'h0, 1'b0, 9'd0, 1'b0, 16'h0, "drain0");
    cyc(1'b0, 1'b0, 9'd0, 16'h0, 1'b0, 9'd0, 1'b0, 16'h0, "drain1");
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
